// File: rtl/uart_echo_pkg.sv
// Shared constants and types for the UART echo/pattern controller.
package uart_echo_pkg;

  localparam logic [1:0] MODE_PASS    = 2'd0;
  localparam logic [1:0] MODE_INC     = 2'd1;
  localparam logic [1:0] MODE_UPPER   = 2'd2;
  localparam logic [1:0] MODE_PATTERN = 2'd3;

  localparam logic [7:0] ASCII_LC_A     = 8'h61;
  localparam logic [7:0] ASCII_LC_Z     = 8'h7A;
  localparam logic [7:0] ASCII_CASE_OFS = 8'h20;

  // Handshake FSM states shared by ingress and egress.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } hs_state_e;

endpackage

// File: rtl/uart_echo_fifo.sv
// DEPTH x DATA_W synchronous buffer decoupling ingress from egress.
// Head is visible combinationally from storage; push and pop in one edge both occur.
module uart_echo_fifo #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned LVL_W  = $clog2(DEPTH) + 1
) (
  input  logic              clk_1kHz,
  input  logic              reset,
  input  logic              push,
  input  logic              pop,
  input  logic              flush,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic [LVL_W-1:0]  level,
  output logic              full,
  output logic              empty
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]  level_q, level_d;
  logic              push_ok_c;
  logic              pop_ok_c;

  assign full      = (level_q == LVL_W'(DEPTH));
  assign empty     = (level_q == '0);
  assign push_ok_c = push && !full;
  assign pop_ok_c  = pop && !empty;
  assign dout      = mem_q[rd_ptr_q];
  assign level     = level_q;

  // Next storage, pointers (power-of-2 wrap) and occupancy; flush wins.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (push_ok_c) begin
        mem_d[wr_ptr_q] = din;
        wr_ptr_d        = PTR_W'(wr_ptr_q + 1'b1);
      end
      if (pop_ok_c) begin
        rd_ptr_d = PTR_W'(rd_ptr_q + 1'b1);
      end
      case ({push_ok_c, pop_ok_c})
        2'b10:   level_d = LVL_W'(level_q + 1'b1);
        2'b01:   level_d = LVL_W'(level_q - 1'b1);
        default: level_d = level_q;
      endcase
    end
  end

  // Storage and pointer registers.
  always_ff @(posedge clk_1kHz or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

endmodule

// File: rtl/uart_echo_ctrl.sv
// Paced echo/pattern controller between the UART core FIFOs and the board top.
// Ingress pulls (or generates) bytes into a small buffer; egress drains it to TX.
module uart_echo_ctrl
  import uart_echo_pkg::*;
#(
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned PATTERN_MAX = 65,
  parameter int unsigned CNT_W       = 16
) (
  input  logic                     clk_1kHz,
  input  logic                     reset,
  input  logic [1:0]               mode,
  input  logic                     rx_empty,
  input  logic                     rx_full,
  input  logic [DATA_W-1:0]        rx_data,
  input  logic                     tx_full,
  output logic                     rd_uart,
  output logic                     wr_uart,
  output logic [DATA_W-1:0]        tx_data,
  output logic [DATA_W-1:0]        last_byte,
  output logic [CNT_W-1:0]         echo_count,
  output logic [$clog2(DEPTH):0]   buf_level,
  output logic                     rx_overrun
);

  localparam int unsigned LVL_W = $clog2(DEPTH) + 1;

  hs_state_e         in_state_q, in_state_d;
  hs_state_e         eg_state_q, eg_state_d;
  logic [1:0]        mode_q, mode_d;
  logic              rd_uart_q, rd_uart_d;
  logic              wr_uart_q, wr_uart_d;
  logic [DATA_W-1:0] tx_data_q, tx_data_d;
  logic [DATA_W-1:0] last_byte_q, last_byte_d;
  logic [CNT_W-1:0]  echo_count_q, echo_count_d;
  logic [DATA_W-1:0] pattern_cnt_q, pattern_cnt_d;
  logic              rx_overrun_q, rx_overrun_d;

  logic              mode_change_c;
  logic              push_c;
  logic              pop_c;
  logic [DATA_W-1:0] push_data_c;
  logic [DATA_W-1:0] head_c;
  logic [LVL_W-1:0]  level_c;
  logic              full_c;
  logic              empty_c;

  // Per-mode byte transform applied on ingress.
  function automatic logic [DATA_W-1:0] xform(input logic [1:0] m, input logic [DATA_W-1:0] d);
    logic [DATA_W-1:0] r;
    r = d;
    case (m)
      MODE_INC: r = DATA_W'(d + 1'b1);
      MODE_UPPER: begin
        if ((d >= DATA_W'(ASCII_LC_A)) && (d <= DATA_W'(ASCII_LC_Z)))
          r = DATA_W'(d - DATA_W'(ASCII_CASE_OFS));
      end
      default: r = d;
    endcase
    return r;
  endfunction

  uart_echo_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .LVL_W  (LVL_W)
  ) u_fifo (
    .clk_1kHz (clk_1kHz),
    .reset    (reset),
    .push     (push_c),
    .pop      (pop_c),
    .flush    (mode_change_c),
    .din      (push_data_c),
    .dout     (head_c),
    .level    (level_c),
    .full     (full_c),
    .empty    (empty_c)
  );

  assign mode_change_c = (mode != mode_q);
  assign mode_d        = mode;
  assign rx_overrun_d  = rx_overrun_q | rx_full;

  // Ingress FSM: one RX pop or pattern push per two cycles, never into a full buffer.
  always_comb begin
    in_state_d    = in_state_q;
    rd_uart_d     = 1'b0;
    push_c        = 1'b0;
    push_data_c   = '0;
    pattern_cnt_d = pattern_cnt_q;
    if (mode_change_c) begin
      in_state_d    = ST_WAIT;
      pattern_cnt_d = '0;
    end else begin
      case (in_state_q)
        ST_IDLE: begin
          if (!full_c) begin
            if (mode_q == MODE_PATTERN) begin
              push_c        = 1'b1;
              push_data_c   = pattern_cnt_q;
              pattern_cnt_d = (pattern_cnt_q == DATA_W'(PATTERN_MAX)) ? '0
                                                                      : DATA_W'(pattern_cnt_q + 1'b1);
              in_state_d    = ST_WAIT;
            end else if (!rx_empty) begin
              rd_uart_d   = 1'b1;
              push_c      = 1'b1;
              push_data_c = xform(mode_q, rx_data);
              in_state_d  = ST_WAIT;
            end
          end
        end
        default: in_state_d = ST_IDLE;
      endcase
    end
  end

  // Egress FSM: one TX push per two cycles while buffer non-empty and TX has room.
  always_comb begin
    eg_state_d   = eg_state_q;
    wr_uart_d    = 1'b0;
    pop_c        = 1'b0;
    tx_data_d    = tx_data_q;
    last_byte_d  = last_byte_q;
    echo_count_d = echo_count_q;
    if (mode_change_c) begin
      eg_state_d = ST_WAIT;
    end else begin
      case (eg_state_q)
        ST_IDLE: begin
          if (!empty_c && !tx_full) begin
            wr_uart_d   = 1'b1;
            tx_data_d   = head_c;
            last_byte_d = head_c;
            pop_c       = 1'b1;
            if (echo_count_q != '1)
              echo_count_d = CNT_W'(echo_count_q + 1'b1);
            eg_state_d  = ST_WAIT;
          end
        end
        default: eg_state_d = ST_IDLE;
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge clk_1kHz or posedge reset) begin
    if (reset) begin
      in_state_q    <= ST_IDLE;
      eg_state_q    <= ST_IDLE;
      mode_q        <= MODE_PASS;
      rd_uart_q     <= 1'b0;
      wr_uart_q     <= 1'b0;
      tx_data_q     <= '0;
      last_byte_q   <= '0;
      echo_count_q  <= '0;
      pattern_cnt_q <= '0;
      rx_overrun_q  <= 1'b0;
    end else begin
      in_state_q    <= in_state_d;
      eg_state_q    <= eg_state_d;
      mode_q        <= mode_d;
      rd_uart_q     <= rd_uart_d;
      wr_uart_q     <= wr_uart_d;
      tx_data_q     <= tx_data_d;
      last_byte_q   <= last_byte_d;
      echo_count_q  <= echo_count_d;
      pattern_cnt_q <= pattern_cnt_d;
      rx_overrun_q  <= rx_overrun_d;
    end
  end

  assign rd_uart    = rd_uart_q;
  assign wr_uart    = wr_uart_q;
  assign tx_data    = tx_data_q;
  assign last_byte  = last_byte_q;
  assign echo_count = echo_count_q;
  assign buf_level  = level_c;
  assign rx_overrun = rx_overrun_q;

endmodule

// File: tb/tb_uart_echo_ctrl.sv
// Directed bench for uart_echo_ctrl with a small model of the UART RX FIFO.
module tb_uart_echo_ctrl;

  logic        clk_1kHz = 1'b0;
  logic        reset    = 1'b1;
  logic [1:0]  mode     = 2'd0;
  logic        rx_empty = 1'b1;
  logic        rx_full  = 1'b0;
  logic [7:0]  rx_data  = 8'h00;
  logic        tx_full  = 1'b0;
  logic        rd_uart;
  logic        wr_uart;
  logic [7:0]  tx_data;
  logic [7:0]  last_byte;
  logic [15:0] echo_count;
  logic [2:0]  buf_level;
  logic        rx_overrun;

  int          n_checks = 0;
  int          n_pass   = 0;
  int          cyc      = 0;
  int          rd_cnt   = 0;
  logic [7:0]  rx_q [$];
  logic [7:0]  tx_log [$];
  int          wr_cyc [$];

  uart_echo_ctrl dut (
    .clk_1kHz   (clk_1kHz),
    .reset      (reset),
    .mode       (mode),
    .rx_empty   (rx_empty),
    .rx_full    (rx_full),
    .rx_data    (rx_data),
    .tx_full    (tx_full),
    .rd_uart    (rd_uart),
    .wr_uart    (wr_uart),
    .tx_data    (tx_data),
    .last_byte  (last_byte),
    .echo_count (echo_count),
    .buf_level  (buf_level),
    .rx_overrun (rx_overrun)
  );

  always #5 clk_1kHz = ~clk_1kHz;

  always @(posedge clk_1kHz) cyc <= cyc + 1;

  // RX FIFO model and TX/RX strobe logger, evaluated mid-cycle.
  always @(negedge clk_1kHz) begin
    if (rd_uart) begin
      rd_cnt++;
      if (rx_q.size() > 0) void'(rx_q.pop_front());
    end
    if (wr_uart) begin
      tx_log.push_back(tx_data);
      wr_cyc.push_back(cyc);
    end
    rx_empty = (rx_q.size() == 0);
    rx_data  = rx_empty ? 8'h00 : rx_q[0];
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(negedge clk_1kHz);
      #1;
    end
  endtask

  task automatic clear_logs();
    tx_log.delete();
    wr_cyc.delete();
    rd_cnt = 0;
  endtask

  initial begin
    int guard;
    int bad;
    logic [7:0] exp_b [6];

    // Reset state
    tick(3);
    check_eq("rst_rd", 32'(rd_uart), 0);
    check_eq("rst_wr", 32'(wr_uart), 0);
    check_eq("rst_tx_data", 32'(tx_data), 0);
    check_eq("rst_last", 32'(last_byte), 0);
    check_eq("rst_echo", 32'(echo_count), 0);
    check_eq("rst_level", 32'(buf_level), 0);
    check_eq("rst_ovr", 32'(rx_overrun), 0);
    reset = 1'b0;
    tick(2);

    // PASS echo: rd then wr on the next cycle
    rx_q.push_back(8'h41);
    guard = 0;
    while (!rd_uart && guard < 10) begin tick(); guard++; end
    check_eq("pass_rd_seen", 32'(rd_uart), 1);
    tick();
    check_eq("pass_rd_drop", 32'(rd_uart), 0);
    check_eq("pass_wr", 32'(wr_uart), 1);
    check_eq("pass_tx", 32'(tx_data), 32'h41);
    check_eq("pass_last", 32'(last_byte), 32'h41);
    check_eq("pass_echo", 32'(echo_count), 1);
    tick(4);

    // INC transform
    mode = 2'd1;
    tick(3);
    clear_logs();
    rx_q.push_back(8'h41);
    rx_q.push_back(8'hFF);
    tick(12);
    check_eq("inc_n", 32'(tx_log.size()), 2);
    if (tx_log.size() >= 2) begin
      check_eq("inc_0", 32'(tx_log[0]), 32'h42);
      check_eq("inc_1", 32'(tx_log[1]), 32'h00);
    end

    // UPPER transform
    mode = 2'd2;
    tick(3);
    clear_logs();
    rx_q.push_back(8'h61);
    rx_q.push_back(8'h7A);
    rx_q.push_back(8'h7B);
    rx_q.push_back(8'h5A);
    tick(16);
    check_eq("up_n", 32'(tx_log.size()), 4);
    if (tx_log.size() >= 4) begin
      check_eq("up_0", 32'(tx_log[0]), 32'h41);
      check_eq("up_1", 32'(tx_log[1]), 32'h5A);
      check_eq("up_2", 32'(tx_log[2]), 32'h7B);
      check_eq("up_3", 32'(tx_log[3]), 32'h5A);
    end
    check_eq("up_echo", 32'(echo_count), 7);

    // Backpressure: buffer fills to 4, rest stays in RX FIFO
    tx_full = 1'b1;
    clear_logs();
    for (int i = 0; i < 6; i++) begin
      exp_b[i] = 8'(8'h10 + i);
      rx_q.push_back(exp_b[i]);
    end
    tick(20);
    check_eq("bp_reads", 32'(rd_cnt), 4);
    check_eq("bp_level", 32'(buf_level), 4);
    check_eq("bp_no_wr", 32'(tx_log.size()), 0);
    check_eq("bp_rx_left", 32'(rx_q.size()), 2);
    tx_full = 1'b0;
    tick(30);
    check_eq("bp_n", 32'(tx_log.size()), 6);
    bad = 0;
    for (int i = 0; i < 6; i++)
      if (i < tx_log.size() && tx_log[i] != exp_b[i]) bad++;
    check_eq("bp_order_errs", 32'(bad), 0);
    if (wr_cyc.size() >= 4)
      check_eq("bp_pace", 32'(wr_cyc[3] - wr_cyc[0]), 6);
    check_eq("bp_echo", 32'(echo_count), 13);
    check_eq("bp_level_end", 32'(buf_level), 0);

    // PATTERN wrap
    mode = 2'd3;
    tick();
    clear_logs();
    guard = 0;
    while (tx_log.size() < 140 && guard < 400) begin tick(); guard++; end
    check_eq("pat_n", 32'(tx_log.size() >= 140), 1);
    bad = 0;
    for (int i = 0; i < 140; i++)
      if (i < tx_log.size() && tx_log[i] != 8'(i % 66)) bad++;
    check_eq("pat_seq_errs", 32'(bad), 0);
    if (tx_log.size() >= 140) begin
      check_eq("pat_65", 32'(tx_log[65]), 65);
      check_eq("pat_wrap", 32'(tx_log[66]), 0);
      check_eq("pat_139", 32'(tx_log[139]), 7);
    end
    check_eq("pat_no_rd", 32'(rd_cnt), 0);

    // Mode change mid-stream: level 3 in PASS, then switch to PATTERN
    mode = 2'd0;
    tick(6);
    tx_full = 1'b1;
    tick(2);
    rx_q.push_back(8'h21);
    rx_q.push_back(8'h22);
    rx_q.push_back(8'h23);
    tick(12);
    check_eq("mc_level3", 32'(buf_level), 3);
    rx_full = 1'b1;
    tick();
    rx_full = 1'b0;
    tick();
    check_eq("ovr_set", 32'(rx_overrun), 1);
    mode    = 2'd3;
    tx_full = 1'b0;
    tick();
    check_eq("mc_flush", 32'(buf_level), 0);
    check_eq("mc_no_wr", 32'(wr_uart), 0);
    check_eq("mc_no_rd", 32'(rd_uart), 0);
    guard = 0;
    while (!wr_uart && guard < 10) begin tick(); guard++; end
    check_eq("mc_wr_seen", 32'(wr_uart), 1);
    check_eq("mc_first_tx", 32'(tx_data), 0);

    // Async reset between edges while wr_uart is high
    tick();
    guard = 0;
    while (!wr_uart && guard < 10) begin tick(); guard++; end
    check_eq("ar_wr_before", 32'(wr_uart), 1);
    reset = 1'b1;
    #1;
    check_eq("ar_wr", 32'(wr_uart), 0);
    check_eq("ar_rd", 32'(rd_uart), 0);
    check_eq("ar_echo", 32'(echo_count), 0);
    check_eq("ar_level", 32'(buf_level), 0);
    check_eq("ar_ovr", 32'(rx_overrun), 0);
    mode = 2'd0;
    tick(2);
    reset = 1'b0;
    tick(2);
    check_eq("ar_ovr_hold0", 32'(rx_overrun), 0);
    rx_full = 1'b1;
    tick();
    rx_full = 1'b0;
    tick();
    check_eq("ar_ovr_set", 32'(rx_overrun), 1);
    tick(5);
    check_eq("ar_ovr_sticky", 32'(rx_overrun), 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_echo_ctrl.md
Name: uart_echo_ctrl

Overview:
Paced echo/pattern controller in the clk_1kHz domain, sitting between the UART core's RX/TX FIFO interface and the board-level top.
- Replaces free-running read/write strobes with a handshaked ingress/egress pair.
- Ingress and egress are decoupled by an internal DEPTH-entry buffer.
- Selectable byte transform (pass, +1, uppercase), plus a pattern generator mode that transmits a wrapping counter.
- Exposes status for LEDs and 7-seg.

Parameters:
DATA_W, 8, byte width of RX/TX data.
DEPTH, 4, internal buffer entries; power of 2, >=2.
PATTERN_MAX, 65, last value of the pattern counter before it wraps to 0.
CNT_W, 16, width of echo_count.

Ports:
clk_1kHz  in  1  block clock.
reset  in  1  asynchronous, active-high.
mode  in  2  0=PASS, 1=INC, 2=UPPER, 3=PATTERN.
rx_empty  in  1  UART RX FIFO empty.
rx_full  in  1  UART RX FIFO full.
rx_data  in  DATA_W  RX FIFO head (first-word-fall-through).
tx_full  in  1  UART TX FIFO full.
rd_uart  out  1  one-cycle RX FIFO pop strobe.
wr_uart  out  1  one-cycle TX FIFO push strobe.
tx_data  out  DATA_W  byte written with wr_uart.
last_byte  out  DATA_W  most recent transmitted byte.
echo_count  out  CNT_W  bytes transmitted, saturating.
buf_level  out  clog2(DEPTH)+1  internal buffer occupancy.
rx_overrun  out  1  sticky: rx_full was seen high.

Behaviour:
- Reset (async): all outputs 0, both FSMs in IDLE, buffer empty, pattern_cnt=0, mode_q=0. Strobes drop immediately.
- All outputs are registered.
- mode is registered into mode_q each cycle.
- Mode change (mode != mode_q):
  - In the cycle it is detected, the buffer is flushed (level=0) and pattern_cnt=0.
  - Both FSMs are forced to WAIT for that cycle; no strobe is issued.
  - echo_count is not cleared.
- Ingress FSM, states IDLE and WAIT:
  - IDLE, mode_q!=PATTERN, !rx_empty, level<DEPTH: rd_uart<=1, push xform(rx_data), go to WAIT.
  - IDLE, mode_q==PATTERN, level<DEPTH: push pattern_cnt, pattern_cnt <= (pattern_cnt==PATTERN_MAX) ? 0 : pattern_cnt+1, go to WAIT. rd_uart stays 0.
  - WAIT: rd_uart<=0, go to IDLE. This gives the core one cycle to update rx_empty, so there is at most one read per 2 cycles.
  - Buffer full: stay in IDLE, no rd_uart. RX bytes stay in the core FIFO.
- xform:
  - PASS: identity.
  - INC: rx_data+1 mod 2^DATA_W (0xFF -> 0x00).
  - UPPER: 0x61..0x7A map to minus 0x20; all other values pass unchanged.
- Egress FSM, states IDLE and WAIT:
  - IDLE, level>0, !tx_full: wr_uart<=1, tx_data<=head, last_byte<=head, pop, echo_count<=min(echo_count+1, 2^CNT_W-1), go to WAIT.
  - WAIT: wr_uart<=0, go to IDLE.
  - tx_full: hold in IDLE. tx_data keeps its last value.
- Latency: a byte pushed at edge n is visible to egress at edge n+1. wr_uart is high in the cycle immediately after rd_uart, given an empty buffer and !tx_full.
- Simultaneous push and pop in the same edge: both occur, level unchanged, and pointers wrap modulo DEPTH.
- Buffer full and pop in the same edge: the pop frees no slot for ingress until the next edge, because ingress uses the registered level.
- rx_overrun: set on any edge where rx_full=1; cleared only by reset.
- Buffer ordering is strictly FIFO; no byte is dropped except by a mode-change flush.

Decomposition:
- Shared package uart_echo_pkg:
  - MODE_PASS/INC/UPPER/PATTERN constants (2-bit).
  - ASCII_LC_A=8'h61, ASCII_LC_Z=8'h7A, ASCII_CASE_OFS=8'h20.
- Sub-module uart_echo_fifo:
  - Synchronous DEPTH x DATA_W buffer, async reset.
  - Ports: push, pop, flush, din, dout (head), level, full, empty.
  - Defined push+pop-same-cycle behaviour.
- Transform function and both FSMs live in uart_echo_ctrl.

Test Plan:
- PASS echo: mode=0, RX FIFO holds 0x41. Expected: rd_uart 1 cycle, then wr_uart the next cycle with tx_data=0x41, last_byte=0x41, echo_count=1.
- INC and UPPER transforms:
  - mode=1: inputs 0x41, 0xFF produce TX 0x42, 0x00.
  - mode=2: inputs 0x61, 0x7A, 0x7B, 0x5A produce TX 0x41, 0x5A, 0x7B, 0x5A.
- Backpressure: tx_full=1, feed 6 bytes.
  - Exactly 4 rd_uart pulses, buf_level=4, no further reads.
  - Release tx_full: 4 writes in original order, 1 every 2 cycles; remaining 2 bytes follow.
- PATTERN wrap: mode=3, tx_full=0, run 140 writes.
  - tx_data sequence 0..65 repeated, 66 follows 65 never, 0 follows 65.
  - rd_uart never asserted.
- Mode change mid-stream: buffer at level 3 in PASS, switch to PATTERN.
  - buf_level=0 next cycle, no strobe that cycle, then first TX byte is 0x00.
- Async reset mid-operation: assert reset between edges while wr_uart=1.
  - wr_uart, rd_uart, echo_count, buf_level, rx_overrun are 0 immediately.
  - After release with rx_full pulsed once, rx_overrun=1 and stays 1.
